// File: rtl/jt7759_romcache.sv
// Two-line, 4-byte-per-line read cache between the ADPCM player ROM port
// and a 32-bit memory port, with optional next-line prefetch.
module jt7759_romcache #(
  parameter bit PREFETCH = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        rom_cs,
  input  logic [16:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        rom_ok,
  output logic        mem_cs,
  output logic [14:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_ok
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PREF
  } state_t;

  state_t      st, st_nx;
  logic [1:0]  valid;
  logic [14:0] tag  [2];
  logic [31:0] data [2];
  logic        lru, victim;
  logic        ok_reg, discard, filled;
  logic [16:0] last_addr;

  logic [14:0] line_a, nxt;
  logic [1:0]  match;
  logic        hit, hidx, cur, miss;
  logic        nxt_in, done, pref_go;
  logic [31:0] hline;
  logic [7:0]  hbyte;

  always_comb begin
    line_a   = rom_addr[16:2];
    match[0] = valid[0] & (tag[0] == line_a);
    match[1] = valid[1] & (tag[1] == line_a);
    hit      = rom_cs & (|match);
    miss     = rom_cs & ~hit;
    hidx     = match[1];
    // most recently used line, counting a hit in this very cycle
    cur      = hit ? hidx : lru;
    nxt      = tag[cur] + 15'd1;
    nxt_in   = (valid[0] & (tag[0] == nxt)) |
               (valid[1] & (tag[1] == nxt));
    hline    = data[hidx];
    hbyte    = hline[{rom_addr[1:0], 3'b000} +: 8];
    done     = (st != IDLE) & mem_ok;
  end

  always_comb begin
    st_nx   = st;
    pref_go = 1'b0;
    unique case (st)
      IDLE: begin
        if (miss) begin
          st_nx = FILL;
        end else if (PREFETCH && !flush && !nxt_in
                     && (hit || filled)) begin
          st_nx   = PREF;
          pref_go = 1'b1;
        end
      end
      FILL, PREF: begin
        if (mem_ok) st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  assign rom_ok = ok_reg & rom_cs & (rom_addr == last_addr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st        <= IDLE;
      valid     <= 2'b00;
      tag[0]    <= '0;
      tag[1]    <= '0;
      data[0]   <= '0;
      data[1]   <= '0;
      lru       <= 1'b0;
      victim    <= 1'b0;
      ok_reg    <= 1'b0;
      discard   <= 1'b0;
      filled    <= 1'b0;
      last_addr <= '0;
      rom_data  <= '0;
      mem_cs    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      st        <= st_nx;
      ok_reg    <= hit & ~flush;
      last_addr <= rom_addr;
      filled    <= 1'b0;
      if (hit) begin
        rom_data <= hbyte;
        lru      <= hidx;
      end
      if (st == IDLE && st_nx != IDLE) begin
        mem_cs   <= 1'b1;
        mem_addr <= pref_go ? nxt : line_a;
        victim   <= ~cur;
        discard  <= 1'b0;
      end else if (flush && st != IDLE) begin
        discard <= 1'b1;
      end
      if (flush) valid <= 2'b00;
      // an in-flight line fetched before a flush lands invalid
      if (done) begin
        mem_cs        <= 1'b0;
        data[victim]  <= mem_data;
        tag[victim]   <= mem_addr;
        valid[victim] <= ~(discard | flush);
        if (st == FILL) begin
          lru    <= victim;
          filled <= ~(discard | flush);
        end
      end
    end
  end

endmodule

// File: tb/tb_jt7759_romcache.sv
// Directed bench for jt7759_romcache: cold fill, streaming, wrap,
// address change, flush and miss-during-prefetch scenarios.
module tb_jt7759_romcache;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        rom_cs;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic        mem_cs;
  logic [14:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ok;

  int errors = 0;
  int checks = 0;
  int mem_lat = 5;
  int mcnt = 0;

  jt7759_romcache #(.PREFETCH(1'b1)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .rom_cs   (rom_cs),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_ok   (rom_ok),
    .mem_cs   (mem_cs),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_ok   (mem_ok)
  );

  always #5 clk = ~clk;

  // ROM contents: byte 4..7 = 11 22 33 44, high address bits mixed in
  function automatic logic [7:0] rom_byte(input logic [16:0] x);
    logic [7:0] t;
    logic [7:0] p;
    t = x[7:0] - 8'd3;
    p = t * 8'h11;
    return p ^ x[15:8];
  endfunction

  function automatic logic [31:0] rom_line(input logic [14:0] a);
    return {rom_byte({a, 2'd3}), rom_byte({a, 2'd2}),
            rom_byte({a, 2'd1}), rom_byte({a, 2'd0})};
  endfunction

  // memory responder: mem_ok after mem_lat cycles of mem_cs
  initial begin
    mem_ok   = 1'b0;
    mem_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_cs && !mem_ok) begin
        mcnt++;
        if (mcnt >= mem_lat) begin
          mem_ok   = 1'b1;
          mem_data = rom_line(mem_addr);
          mcnt     = 0;
        end
      end else begin
        mem_ok = 1'b0;
        mcnt   = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rom_ok(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rom_ok === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_mem(input logic want, input int budget,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (mem_cs === want) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 80 && quiet < 3; i++) begin
      tick();
      if (mem_cs) quiet = 0;
      else quiet++;
    end
    checks++;
    if (quiet < 3) begin
      errors++;
      $display("FAIL idle: got busy want quiet memory port");
    end
  endtask

  task automatic test_reset();
    rstn     = 1'b0;
    flush    = 1'b0;
    rom_cs   = 1'b1;
    rom_addr = 17'h00005;
    tick();
    tick();
    checks++;
    if (rom_ok !== 1'b0) begin
      errors++;
      $display("FAIL reset_rom_ok: got %b want 0", rom_ok);
    end
    checks++;
    if (mem_cs !== 1'b0) begin
      errors++;
      $display("FAIL reset_mem_cs: got %b want 0", mem_cs);
    end
    checks++;
    if (mem_addr !== 15'h0000) begin
      errors++;
      $display("FAIL reset_mem_addr: got %h want 0000", mem_addr);
    end
    checks++;
    if (rom_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rom_data: got %h want 00", rom_data);
    end
    rom_cs = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_cold();
    int memat;
    int okat;
    logic prev_cs;
    mem_lat  = 5;
    rom_cs   = 1'b1;
    rom_addr = 17'h00005;
    tick();
    checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 15'h0001) begin
      errors++;
      $display("FAIL cold_req: got cs=%b addr=%h want cs=1 addr=0001",
               mem_cs, mem_addr);
    end
    memat   = -1;
    okat    = -1;
    prev_cs = mem_cs;
    for (int i = 0; i < 30; i++) begin
      if (mem_ok && memat < 0) memat = i;
      if (rom_ok) begin
        okat = i;
        break;
      end
      prev_cs = mem_cs;
      tick();
    end
    checks++;
    if (okat < 0 || memat < 0 || okat - memat != 2) begin
      errors++;
      $display("FAIL cold_latency: got ok@%0d mem_ok@%0d want gap 2",
               okat, memat);
    end
    checks++;
    if (rom_data !== 8'h22) begin
      errors++;
      $display("FAIL cold_data: got %h want 22", rom_data);
    end
    checks++;
    if (prev_cs !== 1'b0) begin
      errors++;
      $display("FAIL cold_gap: got cs=%b want 0 before prefetch", prev_cs);
    end
    checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 15'h0002) begin
      errors++;
      $display("FAIL cold_pref: got cs=%b addr=%h want cs=1 addr=0002",
               mem_cs, mem_addr);
    end
    rom_cs = 1'b0;
    wait_idle();
  endtask

  task automatic test_stream();
    bit saw2;
    mem_lat = 3;
    saw2    = 1'b0;
    rom_cs  = 1'b1;
    for (int x = 4; x < 12; x++) begin
      rom_addr = 17'(x);
      tick();
      if (mem_cs && mem_addr == 15'h0002) saw2 = 1'b1;
      checks++;
      if (rom_ok !== 1'b1) begin
        errors++;
        $display("FAIL stream_ok[%0h]: got %b want 1", x, rom_ok);
      end
      checks++;
      if (rom_data !== rom_byte(17'(x))) begin
        errors++;
        $display("FAIL stream_data[%0h]: got %h want %h",
                 x, rom_data, rom_byte(17'(x)));
      end
    end
    checks++;
    if (saw2) begin
      errors++;
      $display("FAIL stream_nomem: got fetch of 0002 want none");
    end
    rom_cs = 1'b0;
    wait_idle();
  endtask

  task automatic test_addr_change();
    bit ok;
    mem_lat  = 3;
    rom_cs   = 1'b1;
    rom_addr = 17'h00010;
    wait_rom_ok(40, ok);
    checks++;
    if (!ok || rom_data !== rom_byte(17'h00010)) begin
      errors++;
      $display("FAIL chg_first: got ok=%b data=%h want 1 %h",
               ok, rom_data, rom_byte(17'h00010));
    end
    rom_addr = 17'h00011;
    #1;
    checks++;
    if (rom_ok !== 1'b0) begin
      errors++;
      $display("FAIL chg_stale: got %b want 0", rom_ok);
    end
    tick();
    checks++;
    if (rom_ok !== 1'b1 || rom_data !== rom_byte(17'h00011)) begin
      errors++;
      $display("FAIL chg_new: got ok=%b data=%h want 1 %h",
               rom_ok, rom_data, rom_byte(17'h00011));
    end
    rom_cs = 1'b0;
    #1;
    checks++;
    if (rom_ok !== 1'b0) begin
      errors++;
      $display("FAIL chg_csdrop: got %b want 0", rom_ok);
    end
    wait_idle();
  endtask

  task automatic test_wrap();
    bit ok;
    mem_lat  = 3;
    rom_cs   = 1'b1;
    rom_addr = 17'h1FFFC;
    wait_rom_ok(40, ok);
    checks++;
    if (!ok || rom_data !== rom_byte(17'h1FFFC)) begin
      errors++;
      $display("FAIL wrap_fill: got ok=%b data=%h want 1 %h",
               ok, rom_data, rom_byte(17'h1FFFC));
    end
    wait_mem(1'b1, 10, ok);
    checks++;
    if (!ok || mem_addr !== 15'h0000) begin
      errors++;
      $display("FAIL wrap_pref: got cs=%b addr=%h want cs=1 addr=0000",
               ok, mem_addr);
    end
    rom_cs = 1'b0;
    wait_idle();
    rom_cs   = 1'b1;
    rom_addr = 17'h00000;
    tick();
    checks++;
    if (rom_ok !== 1'b1 || rom_data !== rom_byte(17'h00000)) begin
      errors++;
      $display("FAIL wrap_hit: got ok=%b data=%h want 1 %h",
               rom_ok, rom_data, rom_byte(17'h00000));
    end
    rom_cs = 1'b0;
    wait_idle();
  endtask

  task automatic test_flush();
    bit ok;
    mem_lat  = 5;
    rom_cs   = 1'b1;
    rom_addr = 17'h00400;
    tick();
    checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 15'h0100) begin
      errors++;
      $display("FAIL flush_req: got cs=%b addr=%h want cs=1 addr=0100",
               mem_cs, mem_addr);
    end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_mem(1'b0, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL flush_drop: got cs=%b want 0", mem_cs);
    end
    checks++;
    if (rom_ok !== 1'b0) begin
      errors++;
      $display("FAIL flush_ok: got %b want 0", rom_ok);
    end
    tick();
    checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 15'h0100) begin
      errors++;
      $display("FAIL flush_refetch: got cs=%b addr=%h want cs=1 addr=0100",
               mem_cs, mem_addr);
    end
    wait_rom_ok(30, ok);
    checks++;
    if (!ok || rom_data !== rom_byte(17'h00400)) begin
      errors++;
      $display("FAIL flush_data: got ok=%b data=%h want 1 %h",
               ok, rom_data, rom_byte(17'h00400));
    end
    rom_cs = 1'b0;
    wait_idle();
  endtask

  task automatic test_miss_pref();
    bit ok;
    bit bad;
    bit dropped;
    bit seen;
    mem_lat  = 6;
    rom_cs   = 1'b1;
    rom_addr = 17'h00008;
    wait_rom_ok(40, ok);
    wait_mem(1'b1, 5, ok);
    checks++;
    if (!ok || mem_addr !== 15'h0003) begin
      errors++;
      $display("FAIL mp_pref: got cs=%b addr=%h want cs=1 addr=0003",
               ok, mem_addr);
    end
    rom_addr = 17'h00100;
    bad      = 1'b0;
    dropped  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!mem_cs) begin
        dropped = 1'b1;
        break;
      end
      if (mem_addr != 15'h0003 || rom_ok) bad = 1'b1;
    end
    checks++;
    if (bad || !dropped) begin
      errors++;
      $display("FAIL mp_hold: got bad=%b dropped=%b want 0 1",
               bad, dropped);
    end
    tick();
    checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 15'h0040) begin
      errors++;
      $display("FAIL mp_miss: got cs=%b addr=%h want cs=1 addr=0040",
               mem_cs, mem_addr);
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rom_ok) break;
      if (mem_ok) seen = 1'b1;
      tick();
    end
    checks++;
    if (rom_ok !== 1'b1 || !seen || rom_data !== rom_byte(17'h00100)) begin
      errors++;
      $display("FAIL mp_data: got ok=%b fill=%b data=%h want 1 1 %h",
               rom_ok, seen, rom_data, rom_byte(17'h00100));
    end
    rom_cs = 1'b0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_cold();
    test_stream();
    test_addr_change();
    test_wrap();
    test_flush();
    test_miss_pref();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
